// File: rtl/sccb_cfg_sequencer_if.sv
// Handshake bundle between the OV7670 register-load sequencer and the SCCB master side.
// The master modport belongs to the sequencer; the slave modport belongs to the SCCB master/status consumer.
interface sccb_cfg_sequencer_if;
  logic       start;
  logic       complete;
  logic [7:0] addr_out;
  logic [7:0] data_out;
  logic       write3_rq;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] index;
  logic [2:0] dbg_state;

  // write3_rq is a level request: addr_out/data_out are valid and held while it is
  // high, and the request is accepted when complete is seen high in the same cycle.
  modport master (
    input  start, complete,
    output addr_out, data_out, write3_rq, busy, done, error, index, dbg_state
  );

  modport slave (
    output start, complete,
    input  addr_out, data_out, write3_rq, busy, done, error, index, dbg_state
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Walks a fixed OV7670 (register, value) table and issues one SCCB 3-phase write per entry.
// Optional macro SCCB_CFG_QVGA_EN inserts the three QVGA scaling entries before the terminator.
module sccb_cfg_sequencer #(
  parameter logic [15:0] RESET_WAIT = 16'd2000,
  parameter logic [7:0]  GAP_CYCLES = 8'd16,
  parameter logic [15:0] TIMEOUT    = 16'd65535
) (
  input logic                   Clk,
  input logic                   Reset,
  sccb_cfg_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_REL, S_GAP, S_RST_WAIT, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_index;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_rq;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h1280;
      4'd1:    table_entry = 16'h1204;
      4'd2:    table_entry = 16'h40D0;
      4'd3:    table_entry = 16'h8C00;
      4'd4:    table_entry = 16'h3A04;
      4'd5:    table_entry = 16'h1101;
`ifdef SCCB_CFG_QVGA_EN
      4'd6:    table_entry = 16'h0C04;
      4'd7:    table_entry = 16'h3E19;
      4'd8:    table_entry = 16'h7211;
`endif
      default: table_entry = 16'hFFFF;
    endcase
  endfunction

  logic [15:0] w_entry;
  logic        w_is_term;
  logic        w_to_hit;
  logic        w_gap_hit;
  logic        w_rst_hit;
  logic        w_soft_rst;

  assign w_entry    = table_entry(r_index);
  assign w_is_term  = (w_entry == 16'hFFFF);
  // The request stays high for exactly TIMEOUT cycles (one cycle when TIMEOUT is 0).
  assign w_to_hit   = (TIMEOUT == 16'd0) || (r_cnt == (TIMEOUT - 16'd1));
  assign w_gap_hit  = (r_cnt == {8'd0, GAP_CYCLES});
  assign w_rst_hit  = (r_cnt == RESET_WAIT);
  assign w_soft_rst = ({r_addr, r_data} == 16'h1280);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_index <= 4'd0;
      r_addr  <= 8'd0;
      r_data  <= 8'd0;
      r_rq    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_index <= 4'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_is_term) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_addr  <= w_entry[15:8];
            r_data  <= w_entry[7:0];
            r_rq    <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // complete takes priority over a timeout expiring in the same cycle
          if (bus.complete) begin
            r_rq    <= 1'b0;
            r_state <= S_WAIT_REL;
          end else if (w_to_hit) begin
            r_rq    <= 1'b0;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT_REL: begin
          if (!bus.complete) begin
            r_cnt   <= 16'd0;
            r_state <= w_soft_rst ? S_RST_WAIT : S_GAP;
          end
        end
        S_GAP: begin
          if (w_gap_hit) begin
            r_index <= r_index + 4'd1;
            r_state <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RST_WAIT: begin
          if (w_rst_hit) begin
            r_index <= r_index + 4'd1;
            r_state <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_out  = r_addr;
  assign bus.data_out  = r_data;
  assign bus.write3_rq = r_rq;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.index     = r_index;
  assign bus.dbg_state = r_state;

endmodule
